io_mtimer: RTL and testbench



---
 rtl/io_mtimer.sv | 204 ++++++++++++++++++++
 tb/tb_io_mtimer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/io_mtimer.sv
// Memory-mapped machine timer: 64-bit prescaled mtime, 64-bit mtimecmp, sticky MATCH status.
// Build option IO_MTIMER_SNAPSHOT_EN adds a shadow of mtime[63:32] for tear-free LO-then-HI reads.
module io_mtimer #(
  parameter logic [13:0] BASE_ADR = 14'h3E00,
  parameter int          PRE_W    = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dma_io_we,
  input  logic [13:0] dma_io_wadr,
  input  logic [31:0] dma_io_wdata,
  input  logic [13:0] dma_io_radr,
  input  logic        dma_io_radr_en,
  output logic [31:0] dma_io_rdata,
  output logic        frc_cntr_val_leq
);

  // Bus handshake: no valid/ready pair. A write is accepted on every edge where
  // dma_io_we = 1; a read is accepted on every edge where dma_io_radr_en = 1 and its
  // data is presented on dma_io_rdata for the following cycle (0 when nothing is read).

  localparam logic [2:0]       OFF_MTIME_LO = 3'd0;
  localparam logic [2:0]       OFF_MTIME_HI = 3'd1;
  localparam logic [2:0]       OFF_MCMP_LO  = 3'd2;
  localparam logic [2:0]       OFF_MCMP_HI  = 3'd3;
  localparam logic [2:0]       OFF_CTRL     = 3'd4;
  localparam logic [2:0]       OFF_PRESCALE = 3'd5;
  localparam logic [2:0]       OFF_STATUS   = 3'd6;
  localparam logic [PRE_W-1:0] PRE_ONE      = PRE_W'(1);

  logic [63:0]      mtime;
  logic [63:0]      mcmp;
  logic             ctrl_en;
  logic             ctrl_autoclr;
  logic [PRE_W-1:0] prescale;
  logic [PRE_W-1:0] pcnt;
  logic             match;

`ifdef IO_MTIMER_SNAPSHOT_EN
  logic [31:0] mtime_shadow;
`endif

  // Address decode (offset arithmetic wraps, so addresses below BASE_ADR miss)
  logic [13:0] w_off;
  logic [13:0] r_off;
  logic        w_hit;
  logic        r_hit;

  assign w_off = dma_io_wadr - BASE_ADR;
  assign r_off = dma_io_radr - BASE_ADR;
  assign w_hit = dma_io_we && (w_off < 14'd8);
  assign r_hit = dma_io_radr_en && (r_off < 14'd8);

  logic wr_mtime_lo;
  logic wr_mtime_hi;
  logic wr_mcmp_lo;
  logic wr_mcmp_hi;
  logic wr_ctrl;
  logic wr_prescale;
  logic wr_status;
  logic rd_mtime_lo;

  assign wr_mtime_lo = w_hit && (w_off[2:0] == OFF_MTIME_LO);
  assign wr_mtime_hi = w_hit && (w_off[2:0] == OFF_MTIME_HI);
  assign wr_mcmp_lo  = w_hit && (w_off[2:0] == OFF_MCMP_LO);
  assign wr_mcmp_hi  = w_hit && (w_off[2:0] == OFF_MCMP_HI);
  assign wr_ctrl     = w_hit && (w_off[2:0] == OFF_CTRL);
  assign wr_prescale = w_hit && (w_off[2:0] == OFF_PRESCALE);
  assign wr_status   = w_hit && (w_off[2:0] == OFF_STATUS);
  assign rd_mtime_lo = r_hit && (r_off[2:0] == OFF_MTIME_LO);

  // Counter next-state
  logic             pre_tick;
  logic             auto_clr;
  logic             mtime_wr;
  logic [63:0]      mtime_nxt;
  logic [PRE_W-1:0] pcnt_nxt;
  logic             leq_nxt;
  logic             match_nxt;

  assign pre_tick = ctrl_en && (pcnt == prescale);
  assign auto_clr = ctrl_autoclr && ctrl_en && frc_cntr_val_leq;
  assign mtime_wr = wr_mtime_lo || wr_mtime_hi;

  always_comb begin
    mtime_nxt = mtime;
    if (auto_clr) begin
      mtime_nxt = 64'd0;
    end else if (pre_tick) begin
      mtime_nxt = mtime + 64'd1;
    end
    // Software writes replace only their half and suppress any carry this cycle.
    if (wr_mtime_lo) begin
      mtime_nxt = {mtime[63:32], dma_io_wdata};
    end else if (wr_mtime_hi) begin
      mtime_nxt = {dma_io_wdata, mtime[31:0]};
    end
  end

  always_comb begin
    pcnt_nxt = pcnt;
    if (ctrl_en) begin
      if (auto_clr || (pcnt == prescale)) begin
        pcnt_nxt = '0;
      end else begin
        pcnt_nxt = pcnt + PRE_ONE;
      end
    end
    if (wr_prescale) begin
      pcnt_nxt = '0;
    end
  end

  // When auto-clear returns mtime to zero the compare is dropped for that edge,
  // so each period produces a single-cycle leq pulse.
  always_comb begin
    leq_nxt = (mcmp <= mtime);
    if (auto_clr && !mtime_wr) begin
      leq_nxt = 1'b0;
    end
  end

  always_comb begin
    match_nxt = match;
    if (wr_status && dma_io_wdata[0]) begin
      match_nxt = 1'b0;
    end
    if (leq_nxt && !frc_cntr_val_leq) begin
      match_nxt = 1'b1;
    end
  end

  // Read mux samples pre-write register values
  logic [31:0] rd_val;

  always_comb begin
    rd_val = 32'd0;
    if (r_hit) begin
      case (r_off[2:0])
        OFF_MTIME_LO: rd_val = mtime[31:0];
`ifdef IO_MTIMER_SNAPSHOT_EN
        OFF_MTIME_HI: rd_val = mtime_shadow;
`else
        OFF_MTIME_HI: rd_val = mtime[63:32];
`endif
        OFF_MCMP_LO:  rd_val = mcmp[31:0];
        OFF_MCMP_HI:  rd_val = mcmp[63:32];
        OFF_CTRL:     rd_val = {30'd0, ctrl_autoclr, ctrl_en};
        OFF_PRESCALE: rd_val = 32'(prescale);
        OFF_STATUS:   rd_val = {31'd0, match};
        default:      rd_val = 32'd0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      mtime            <= 64'd0;
      mcmp             <= 64'hFFFF_FFFF_FFFF_FFFF;
      ctrl_en          <= 1'b0;
      ctrl_autoclr     <= 1'b0;
      prescale         <= '0;
      pcnt             <= '0;
      match            <= 1'b0;
      dma_io_rdata     <= 32'd0;
      frc_cntr_val_leq <= 1'b0;
    end else begin
      mtime            <= mtime_nxt;
      pcnt             <= pcnt_nxt;
      match            <= match_nxt;
      dma_io_rdata     <= rd_val;
      frc_cntr_val_leq <= leq_nxt;
      if (wr_mcmp_lo) begin
        mcmp[31:0] <= dma_io_wdata;
      end
      if (wr_mcmp_hi) begin
        mcmp[63:32] <= dma_io_wdata;
      end
      if (wr_ctrl) begin
        ctrl_en      <= dma_io_wdata[0];
        ctrl_autoclr <= dma_io_wdata[1];
      end
      if (wr_prescale) begin
        prescale <= dma_io_wdata[PRE_W-1:0];
      end
    end
  end

`ifdef IO_MTIMER_SNAPSHOT_EN
  always_ff @(posedge clk) begin
    if (rst_n) begin
      mtime_shadow <= 32'd0;
    end else if (wr_mtime_hi) begin
      mtime_shadow <= dma_io_wdata;
    end else if (rd_mtime_lo) begin
      mtime_shadow <= mtime[63:32];
    end
  end
`else
  logic unused_rd_lo;
  assign unused_rd_lo = rd_mtime_lo;
`endif

endmodule

// File: tb/tb_io_mtimer.sv
// Directed bench for io_mtimer: register map, prescaler, carry/wrap, compare/MATCH,
// AUTOCLR, miss decoding, read/write collision, snapshot option and mid-run reset.
module tb_io_mtimer;

  localparam logic [13:0] BASE = 14'h3E00;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dma_io_we;
  logic [13:0] dma_io_wadr;
  logic [31:0] dma_io_wdata;
  logic [13:0] dma_io_radr;
  logic        dma_io_radr_en;
  logic [31:0] dma_io_rdata;
  logic        frc_cntr_val_leq;

  int n_tests = 0;
  int n_fail  = 0;

  io_mtimer #(.BASE_ADR(BASE), .PRE_W(16)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .dma_io_we        (dma_io_we),
    .dma_io_wadr      (dma_io_wadr),
    .dma_io_wdata     (dma_io_wdata),
    .dma_io_radr      (dma_io_radr),
    .dma_io_radr_en   (dma_io_radr_en),
    .dma_io_rdata     (dma_io_rdata),
    .frc_cntr_val_leq (frc_cntr_val_leq)
  );

  // Clock and reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Driver tasks
  task automatic wr(input logic [13:0] off, input logic [31:0] data);
    dma_io_we    = 1'b1;
    dma_io_wadr  = BASE + off;
    dma_io_wdata = data;
    tick();
    dma_io_we    = 1'b0;
  endtask

  task automatic rd(input logic [13:0] off, output logic [31:0] data);
    dma_io_radr_en = 1'b1;
    dma_io_radr    = BASE + off;
    tick();
    dma_io_radr_en = 1'b0;
    data = dma_io_rdata;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rd_check(input string tag, input logic [13:0] off, input logic [31:0] exp);
    logic [31:0] v;
    rd(off, v);
    check(tag, v, exp);
  endtask

  logic [31:0] reset_vals [8] = '{32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                  32'h0, 32'h0, 32'h0, 32'h0};
  logic [31:0] ac_mtime [10] = '{0, 1, 2, 3, 4, 0, 1, 2, 3, 4};
  logic [31:0] ac_leq   [10] = '{0, 0, 0, 1, 0, 0, 0, 0, 1, 0};
  logic [31:0] snap_hi_exp;

  initial begin
    logic [31:0] v;
    rst_n          = 1'b1;
    dma_io_we      = 1'b0;
    dma_io_wadr    = '0;
    dma_io_wdata   = '0;
    dma_io_radr    = '0;
    dma_io_radr_en = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;

    // Reset state
    check("rst_leq", {31'd0, frc_cntr_val_leq}, 32'd0);
    check("rst_rdata", dma_io_rdata, 32'd0);
    for (int i = 0; i < 8; i++) begin
      rd(14'(i), v);
      check($sformatf("rst_reg%0d", i), v, reset_vals[i]);
    end
    tick();
    check("rdata_idle", dma_io_rdata, 32'd0);

    // Prescaler 3: one increment every 4 cycles
    wr(14'd5, 32'd3);
    wr(14'd4, 32'd1);
    repeat (40) tick();
    rd_check("pre_40cyc", 14'd0, 32'd10);
    repeat (2) tick();
    rd_check("pre_before_inc", 14'd0, 32'd10);
    rd_check("pre_after_inc", 14'd0, 32'd11);
    wr(14'd4, 32'd0);
    repeat (6) tick();
    rd_check("pre_frozen", 14'd0, 32'd11);
    rd_check("prescale_rd", 14'd5, 32'd3);
    rd_check("ctrl_rd", 14'd4, 32'd0);

    // Carry from LO into HI
    wr(14'd5, 32'd0);
    wr(14'd0, 32'hFFFF_FFFE);
    wr(14'd1, 32'd0);
    wr(14'd4, 32'd1);
    tick();
    wr(14'd4, 32'd0);
    rd_check("carry_hi", 14'd1, 32'd1);
    rd_check("carry_lo", 14'd0, 32'd0);

    // 64-bit wrap (all-ones also meets mcmp reset value, so MATCH sets)
    wr(14'd0, 32'hFFFF_FFFF);
    wr(14'd1, 32'hFFFF_FFFF);
    wr(14'd4, 32'd1);
    wr(14'd4, 32'd0);
    rd_check("wrap_lo", 14'd0, 32'd0);
    rd_check("wrap_hi", 14'd1, 32'd0);
    rd_check("wrap_match", 14'd6, 32'd1);
    wr(14'd6, 32'd1);
    rd_check("wrap_match_clr", 14'd6, 32'd0);

    // Compare at 5
    wr(14'd2, 32'd5);
    wr(14'd3, 32'd0);
    wr(14'd4, 32'd1);
    repeat (5) tick();
    check("leq_at_mtime5", {31'd0, frc_cntr_val_leq}, 32'd0);
    tick();
    check("leq_rise", {31'd0, frc_cntr_val_leq}, 32'd1);
    rd_check("match_set", 14'd6, 32'd1);
    wr(14'd6, 32'd1);
    rd_check("match_w1c", 14'd6, 32'd0);

    // Set/clear collision: STATUS write on the leq rising edge
    wr(14'd4, 32'd0);
    wr(14'd0, 32'd0);
    wr(14'd6, 32'd1);
    rd_check("match_pre_coll", 14'd6, 32'd0);
    wr(14'd4, 32'd1);
    repeat (5) tick();
    wr(14'd6, 32'd1);
    rd_check("match_coll", 14'd6, 32'd1);
    check("leq_coll", {31'd0, frc_cntr_val_leq}, 32'd1);
    wr(14'd4, 32'd0);
    wr(14'd6, 32'd1);

    // AUTOCLR with mcmp = 3
    wr(14'd2, 32'd3);
    wr(14'd0, 32'd0);
    tick();
    wr(14'd4, 32'd3);
    for (int i = 0; i < 10; i++) begin
      rd(14'd0, v);
      check($sformatf("ac_mtime%0d", i), v, ac_mtime[i]);
      check($sformatf("ac_leq%0d", i), {31'd0, frc_cntr_val_leq}, ac_leq[i]);
    end
    wr(14'd4, 32'd0);
    rd_check("ac_match", 14'd6, 32'd1);

    // Miss and reserved addresses
    rd_check("miss_rd", 14'd8, 32'd0);
    wr(14'd8, 32'hFFFF_FFFF);
    wr(14'h3FFF, 32'hFFFF_FFFF);
    wr(14'd7, 32'hFFFF_FFFF);
    rd_check("miss_ctrl", 14'd4, 32'd0);
    rd_check("miss_pre", 14'd5, 32'd0);
    rd_check("miss_mcmp_lo", 14'd2, 32'd3);
    rd_check("miss_mcmp_hi", 14'd3, 32'd0);
    rd_check("miss_mtime_lo", 14'd0, 32'd1);
    rd_check("miss_mtime_hi", 14'd1, 32'd0);
    rd_check("resv_rd", 14'd7, 32'd0);

    // Read and write of the same register in one cycle
    dma_io_we      = 1'b1;
    dma_io_wadr    = BASE + 14'd2;
    dma_io_wdata   = 32'd7;
    dma_io_radr_en = 1'b1;
    dma_io_radr    = BASE + 14'd2;
    tick();
    dma_io_we      = 1'b0;
    dma_io_radr_en = 1'b0;
    check("rw_pre_value", dma_io_rdata, 32'd3);
    rd_check("rw_post_value", 14'd2, 32'd7);

    // Snapshot: LO read, HI read 5 cycles later
`ifdef IO_MTIMER_SNAPSHOT_EN
    snap_hi_exp = 32'd1;
`else
    snap_hi_exp = 32'd2;
`endif
    wr(14'd0, 32'hFFFF_FFFF);
    wr(14'd1, 32'd1);
    wr(14'd4, 32'd1);
    rd_check("snap_lo", 14'd0, 32'hFFFF_FFFF);
    repeat (4) tick();
    rd_check("snap_hi", 14'd1, snap_hi_exp);
    wr(14'd4, 32'd0);
    wr(14'd1, 32'd5);
    rd_check("hi_write", 14'd1, 32'd5);

    // Reset mid-operation with a read in flight
    wr(14'd4, 32'd1);
    dma_io_radr_en = 1'b1;
    dma_io_radr    = BASE + 14'd2;
    rst_n          = 1'b1;
    tick();
    dma_io_radr_en = 1'b0;
    check("rst_inflight_rd", dma_io_rdata, 32'd0);
    check("rst_mid_leq", {31'd0, frc_cntr_val_leq}, 32'd0);
    rst_n = 1'b0;
    rd_check("rst_mid_mcmp", 14'd2, 32'hFFFF_FFFF);
    rd_check("rst_mid_ctrl", 14'd4, 32'd0);
    rd_check("rst_mid_lo", 14'd0, 32'd0);
    rd_check("rst_mid_hi", 14'd1, 32'd0);
    rd_check("rst_mid_status", 14'd6, 32'd0);
    rd_check("rst_mid_pre", 14'd5, 32'd0);

    // Report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
